// File: rtl/exec_unit_mc_if.sv
// Instruction handshake, retirement, status and debug-read bundle for exec_unit_mc.
interface exec_unit_mc_if #(parameter int XLEN = 32);
  logic            inst_valid;
  logic [31:0]     inst;
  logic            inst_ready;
  logic            done;
  logic [XLEN-1:0] result;
  logic            halt;
  logic            err;
  logic [4:0]      dbg_raddr;
  logic [XLEN-1:0] dbg_rdata;

  modport master (output inst_valid, inst, dbg_raddr,
                  input  inst_ready, done, result, halt, err, dbg_rdata);
  modport slave  (input  inst_valid, inst, dbg_raddr,
                  output inst_ready, done, result, halt, err, dbg_rdata);
endinterface

// File: rtl/exec_unit_mc.sv
// Multi-cycle RV32I subset execution unit (IDLE/DECODE/EXEC/MEM/WB) with private data memory.
// Optional macro EXEC_MISALIGN_TRAP_EN: trap misaligned LW/SW into the sticky err flag.
module exec_unit_mc #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int DMEM_DEPTH = 256
) (
  input  logic           clk,
  input  logic           rst,
  exec_unit_mc_if.slave  bus
);
  localparam int AW  = $clog2(DMEM_DEPTH);
  localparam int BW  = $clog2(XLEN/8);
  localparam int SHW = $clog2(XLEN);
  localparam int RW  = $clog2(NREG);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111,
                         OP_LD = 7'b0000011, OP_ST = 7'b0100011;

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [2:0] {K_NOP, K_ALU, K_LUI, K_LW, K_SW, K_ECALL} kind_t;

  state_t state, nstate;
  kind_t  kind;
  logic [31:0]                 ir;
  logic [NREG-1:0][XLEN-1:0]   rf;
  logic [XLEN-1:0]             a_q, b_q, imm_q, result_q;
  logic [XLEN-1:0]             imm, src2, alu, addr;
  logic [SHW-1:0]              sh;
  logic [AW-1:0]               idx_q;
  logic                        mis_c, mis_q, halt_q, ready, accept;
  logic [XLEN-1:0]             dmem [DMEM_DEPTH];

  wire [6:0] opc = ir[6:0];
  wire [2:0] f3  = ir[14:12];
  wire [6:0] f7  = ir[31:25];
  wire [4:0] rd  = ir[11:7];
  wire [4:0] rs1 = ir[19:15];
  wire [4:0] rs2 = ir[24:20];

  function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] i,
                                             input logic [NREG-1:0][XLEN-1:0] regs);
    rd_reg = (i == 5'd0 || int'(i) >= NREG) ? '0 : regs[i[RW-1:0]];
  endfunction

  // Decode keys off the held instruction word; it stays stable until the next accept.
  always_comb begin
    kind = K_NOP;
    case (opc)
      OP_R:   if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) kind = K_ALU;
      OP_I: begin
        if (f3 == 3'd1) begin
          if (ir[31:26] == 6'd0 && (XLEN == 64 || !ir[25])) kind = K_ALU;
        end else if (f3 == 3'd5) begin
          if ((ir[31:26] == 6'd0 || ir[31:26] == 6'b010000) && (XLEN == 64 || !ir[25]))
            kind = K_ALU;
        end else kind = K_ALU;
      end
      OP_LUI: kind = K_LUI;
      OP_LD:  if (f3 == 3'd2) kind = K_LW;
      OP_ST:  if (f3 == 3'd2) kind = K_SW;
      default: if (ir == 32'h0000_0073) kind = K_ECALL;
    endcase
  end

  always_comb begin
    if (kind == K_SW)       imm = XLEN'($signed({ir[31:25], ir[11:7]}));
    else if (kind == K_LUI) imm = XLEN'($signed({ir[31:12], 12'b0}));
    else                    imm = XLEN'($signed(ir[31:20]));
  end

  always_comb begin
    src2 = (opc == OP_R) ? b_q : imm_q;
    sh   = src2[SHW-1:0];
    addr = a_q + imm_q;
    alu  = '0;
    case (f3)
      3'd0: alu = (opc == OP_R && ir[30]) ? a_q - src2 : a_q + src2;
      3'd1: alu = a_q << sh;
      3'd2: alu = XLEN'($signed(a_q) < $signed(src2));
      3'd3: alu = XLEN'(a_q < src2);
      3'd4: alu = a_q ^ src2;
      3'd5: alu = ir[30] ? XLEN'($signed(a_q) >>> sh) : a_q >> sh;
      3'd6: alu = a_q | src2;
      default: alu = a_q & src2;
    endcase
  end

`ifdef EXEC_MISALIGN_TRAP_EN
  assign mis_c = (kind == K_LW || kind == K_SW) && (|addr[BW-1:0]);
`else
  assign mis_c = 1'b0;
`endif
  logic unused_addr;
  assign unused_addr = ^addr;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept) nstate = DECODE;
      DECODE:  nstate = EXEC;
      EXEC:    nstate = (kind == K_LW || kind == K_SW) ? MEM : WB;
      MEM:     nstate = WB;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    ready    = (state == IDLE) && !halt_q;
    bus.done = (state == WB);
  end

  assign accept         = bus.inst_valid && ready;
  assign bus.inst_ready = ready;
  assign bus.result     = result_q;
  assign bus.halt       = halt_q;
  assign bus.dbg_rdata  = rd_reg(bus.dbg_raddr, rf);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ir <= '0; a_q <= '0; b_q <= '0; imm_q <= '0; result_q <= '0;
      idx_q <= '0; mis_q <= 1'b0; halt_q <= 1'b0; rf <= '0;
    end else begin
      case (state)
        IDLE:   if (accept) ir <= bus.inst;
        DECODE: begin
          a_q   <= rd_reg(rs1, rf);
          b_q   <= rd_reg(rs2, rf);
          imm_q <= imm;
        end
        EXEC: begin
          idx_q <= addr[AW+BW-1:BW];
          mis_q <= mis_c;
          case (kind)
            K_ALU:      result_q <= alu;
            K_LUI:      result_q <= imm_q;
            K_LW, K_SW: result_q <= mis_c ? '0 : addr;
            default:    result_q <= '0;
          endcase
        end
        MEM: if (kind == K_LW && !mis_q) result_q <= dmem[idx_q];
        default: begin
          if ((kind == K_ALU || kind == K_LUI || kind == K_LW) && !mis_q &&
              rd != 5'd0 && int'(rd) < NREG)
            rf[rd[RW-1:0]] <= result_q;
          if (kind == K_ECALL) halt_q <= 1'b1;
        end
      endcase
    end
  end

  // Memory has no reset; a store is dropped if reset is asserted at its MEM edge.
  always_ff @(posedge clk) begin
    if (rst && state == MEM && kind == K_SW && !mis_q) dmem[idx_q] <= b_q;
  end

`ifdef EXEC_MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else if (state == MEM && mis_q) err_q <= 1'b1;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed vector bench for exec_unit_mc: instruction table plus reset/halt corner sequences.
module tb_exec_unit_mc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exec_unit_mc_if #(.XLEN(32)) bus();
  exec_unit_mc #(.XLEN(32), .NREG(32), .DMEM_DEPTH(256)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    string       name;
    logic [31:0] inst;
    int          lat;
    logic        chk_res;
    logic [31:0] res;
    logic [4:0]  dreg;
    logic [31:0] dval;
  } vec_t;

  vec_t vt[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic dbg(input logic [4:0] r, output logic [31:0] v);
    bus.dbg_raddr = r;
    #1 v = bus.dbg_rdata;
  endtask

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic run(input logic [31:0] i, output int lat, output logic [31:0] res);
    int w = 0;
    lat = 0; res = '0;
    while (!bus.inst_ready && w < 20) begin @(negedge clk); w++; end
    bus.inst_valid = 1'b1; bus.inst = i;
    @(posedge clk); #1 bus.inst_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.done) begin lat = n; res = bus.result; break; end
    end
    @(negedge clk);
    check("done_pulse", {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int dn;
    logic [31:0] res, v;
    logic trap;
`ifdef EXEC_MISALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    vt.push_back('{"addi_x1",  32'h00500093, 3, 1'b1, 32'd5,        5'd1,  32'd5});
    vt.push_back('{"addi_x2",  32'hFFD00113, 3, 1'b1, 32'hFFFFFFFD, 5'd2,  32'hFFFFFFFD});
    vt.push_back('{"sub",      32'h402081B3, 3, 1'b1, 32'd8,        5'd3,  32'd8});
    vt.push_back('{"slt",      32'h00112233, 3, 1'b1, 32'd1,        5'd4,  32'd1});
    vt.push_back('{"sltu",     32'h001132B3, 3, 1'b1, 32'd0,        5'd5,  32'd0});
    vt.push_back('{"sw8",      32'h00102423, 4, 1'b0, 32'd0,        5'd1,  32'd5});
    vt.push_back('{"lw1032",   32'h40802303, 4, 1'b1, 32'd5,        5'd6,  32'd5});
    vt.push_back('{"addi_x0",  32'h00700013, 3, 1'b1, 32'd7,        5'd0,  32'd0});
    vt.push_back('{"lui",      32'h123453B7, 3, 1'b1, 32'h12345000, 5'd7,  32'h12345000});
    vt.push_back('{"srai",     32'h40115413, 3, 1'b1, 32'hFFFFFFFE, 5'd8,  32'hFFFFFFFE});
    vt.push_back('{"sll",      32'h001094B3, 3, 1'b1, 32'h000000A0, 5'd9,  32'h000000A0});
    vt.push_back('{"xori",     32'hFFF0C513, 3, 1'b1, 32'hFFFFFFFA, 5'd10, 32'hFFFFFFFA});
    vt.push_back('{"unsup",    32'h0000057F, 3, 1'b1, 32'd0,        5'd10, 32'hFFFFFFFA});
    vt.push_back('{"srl",      32'h001155B3, 3, 1'b1, 32'h07FFFFFF, 5'd11, 32'h07FFFFFF});
    vt.push_back('{"sw0",      32'h00102023, 4, 1'b0, 32'd0,        5'd1,  32'd5});
    vt.push_back('{"lw_mis",   32'h00202383, 4, 1'b1, trap ? 32'd0 : 32'd5, 5'd7,
                   trap ? 32'h12345000 : 32'd5});

    rst = 1'b0; bus.inst_valid = 1'b0; bus.inst = '0; bus.dbg_raddr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    check("rst_ready",  {31'b0, bus.inst_ready}, 32'd1);
    check("rst_done",   {31'b0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_halt",   {31'b0, bus.halt}, 32'd0);
    check("rst_err",    {31'b0, bus.err}, 32'd0);
    dbg(5'd1, v); check("rst_x1", v, 32'd0);
    @(negedge clk);

    foreach (vt[k]) begin
      run(vt[k].inst, lat, res);
      check({vt[k].name, "_lat"}, lat, vt[k].lat);
      if (vt[k].chk_res) check({vt[k].name, "_res"}, res, vt[k].res);
      dbg(vt[k].dreg, v);
      check({vt[k].name, "_dbg"}, v, vt[k].dval);
    end
    check("err_after_mis", {31'b0, bus.err}, {31'b0, trap});

    // Store of x2 to word 4, then reset lands on the MEM edge of a store of x1 there.
    run(32'h00202823, lat, res);
    check("sw16_lat", lat, 4);
    bus.inst_valid = 1'b1; bus.inst = 32'h00102823;
    @(posedge clk); #1 bus.inst_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    check("abort_ready",  {31'b0, bus.inst_ready}, 32'd1);
    check("abort_done",   {31'b0, bus.done}, 32'd0);
    check("abort_result", bus.result, 32'd0);
    check("abort_err",    {31'b0, bus.err}, 32'd0);
    dbg(5'd1, v); check("abort_x1", v, 32'd0);
    dbg(5'd2, v); check("abort_x2", v, 32'd0);
    @(negedge clk);
    run(32'h01002603, lat, res);
    check("lw16_lat", lat, 4);
    check("lw16_res", res, 32'hFFFFFFFD);
    dbg(5'd12, v); check("lw16_x12", v, 32'hFFFFFFFD);

    run(32'h00000073, lat, res);
    check("ecall_lat", lat, 3);
    check("ecall_res", res, 32'd0);
    check("halt_set",  {31'b0, bus.halt}, 32'd1);
    check("halt_ready", {31'b0, bus.inst_ready}, 32'd0);
    bus.inst_valid = 1'b1; bus.inst = 32'h00100693;
    dn = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    bus.inst_valid = 1'b0;
    check("halt_no_done", dn, 0);
    dbg(5'd13, v); check("halt_x13", v, 32'd0);
    check("halt_sticky", {31'b0, bus.halt}, 32'd1);
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    check("unhalt_halt",  {31'b0, bus.halt}, 32'd0);
    check("unhalt_ready", {31'b0, bus.inst_ready}, 32'd1);
    @(negedge clk);
    run(32'h00500093, lat, res);
    check("post_lat", lat, 3);
    check("post_res", res, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
